// File: rtl/alu_opcodes_pkg.sv
// Opcode map, FSM state encoding and opcode helpers shared by the
// sequential RISC-V ALU and its bench.
package alu_opcodes_pkg;

  typedef logic [4:0] alu_op_t;

  localparam alu_op_t ALU_ADD    = 5'd0;
  localparam alu_op_t ALU_SUB    = 5'd1;
  localparam alu_op_t ALU_XOR    = 5'd2;
  localparam alu_op_t ALU_OR     = 5'd3;
  localparam alu_op_t ALU_AND    = 5'd4;
  localparam alu_op_t ALU_SLL    = 5'd5;
  localparam alu_op_t ALU_SRL    = 5'd6;
  localparam alu_op_t ALU_SRA    = 5'd7;
  localparam alu_op_t ALU_SLTS   = 5'd8;
  localparam alu_op_t ALU_SLTU   = 5'd9;
  localparam alu_op_t ALU_LTS    = 5'd10;
  localparam alu_op_t ALU_LTU    = 5'd11;
  localparam alu_op_t ALU_GES    = 5'd12;
  localparam alu_op_t ALU_GEU    = 5'd13;
  localparam alu_op_t ALU_EQ     = 5'd14;
  localparam alu_op_t ALU_NE     = 5'd15;
  localparam alu_op_t ALU_MUL    = 5'd16;
  localparam alu_op_t ALU_MULH   = 5'd17;
  localparam alu_op_t ALU_MULHSU = 5'd18;
  localparam alu_op_t ALU_MULHU  = 5'd19;
  localparam alu_op_t ALU_DIV    = 5'd20;
  localparam alu_op_t ALU_DIVU   = 5'd21;
  localparam alu_op_t ALU_REM    = 5'd22;
  localparam alu_op_t ALU_REMU   = 5'd23;

  typedef logic [1:0] alu_seq_state_t;

  localparam alu_seq_state_t ST_IDLE = 2'd0;
  localparam alu_seq_state_t ST_DIV  = 2'd1;
  localparam alu_seq_state_t ST_DONE = 2'd2;

  function automatic logic is_div_op(input alu_op_t op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/div_iter_riscv.sv
// Unsigned restoring divider, one quotient bit per clock. quo_o/rem_o carry
// the result of the iteration in progress, so they are final while done_o=1.
module div_iter_riscv #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o
);

  localparam int CNT_W = $clog2(XLEN);

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  quo_q, rem_q, dsr_q;
  logic [XLEN:0]    trial;
  logic             ge;

  // Partial remainder stays below the divisor, so one extra bit holds the borrow.
  assign trial  = {rem_q, quo_q[XLEN-1]} - {1'b0, dsr_q};
  assign ge     = ~trial[XLEN];
  assign rem_o  = ge ? trial[XLEN-1:0] : {rem_q[XLEN-2:0], quo_q[XLEN-1]};
  assign quo_o  = {quo_q[XLEN-2:0], ge};
  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == CNT_W'(XLEN - 1));

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state always uses non-blocking assignment so every
    // register samples pre-edge values regardless of statement order.
    if (rst_i || kill_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (busy_q) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (done_o) busy_q <= 1'b0;
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded by
  // start_i before busy_q lets anything observe them.
  always_ff @(posedge clk_i) begin
    if (start_i) begin
      quo_q <= dividend_i;
      rem_q <= '0;
      dsr_q <= divisor_i;
    end else if (busy_q) begin
      quo_q <= quo_o;
      rem_q <= rem_o;
    end
  end

endmodule

// File: rtl/alu_seq_riscv.sv
// Handshaked RV32I/M execute-stage ALU: single-cycle ops and multiplies,
// iterative divide with sign handling, fast paths and kill.
module alu_seq_riscv
  import alu_opcodes_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            kill_i,
  input  logic [4:0]      alu_op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic            flag_o
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  alu_seq_state_t    state_q;
  logic              valid_q, flag_q;
  logic [XLEN-1:0]   result_q;
  logic              q_neg_q, r_neg_q, rem_sel_q;

  logic              accept, signed_div, rem_op, a_neg, b_neg, div_fast, div_start;
  logic [XLEN-1:0]   a_mag, b_mag, res_c;
  logic              flag_c;
  logic              mul_a_sgn, mul_b_sgn;
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic              div_busy, div_done;
  logic [XLEN-1:0]   div_quo, div_rem, q_fix, r_fix;

  assign ready_o    = (state_q == ST_IDLE) && !div_busy;
  assign accept     = valid_i && ready_o && !kill_i;
  assign signed_div = (alu_op_i == ALU_DIV) || (alu_op_i == ALU_REM);
  assign rem_op     = (alu_op_i == ALU_REM) || (alu_op_i == ALU_REMU);
  assign a_neg      = signed_div && a_i[XLEN-1];
  assign b_neg      = signed_div && b_i[XLEN-1];
  assign a_mag      = a_neg ? -a_i : a_i;
  assign b_mag      = b_neg ? -b_i : b_i;
  assign div_fast   = (b_i == '0) || (signed_div && (a_i == MIN_NEG) && (b_i == '1));
  assign div_start  = accept && is_div_op(alu_op_i) && !div_fast;

  // One 2*XLEN multiplier covers all four variants by choosing the operand extension.
  assign mul_a_sgn = (alu_op_i == ALU_MULH) || (alu_op_i == ALU_MULHSU);
  assign mul_b_sgn = (alu_op_i == ALU_MULH);
  assign mul_a     = {{XLEN{mul_a_sgn & a_i[XLEN-1]}}, a_i};
  assign mul_b     = {{XLEN{mul_b_sgn & b_i[XLEN-1]}}, b_i};
  assign prod      = mul_a * mul_b;

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch.
    res_c  = '0;
    flag_c = 1'b0;
    case (alu_op_i)
      ALU_ADD:    res_c = a_i + b_i;
      ALU_SUB:    res_c = a_i - b_i;
      ALU_XOR:    res_c = a_i ^ b_i;
      ALU_OR:     res_c = a_i | b_i;
      ALU_AND:    res_c = a_i & b_i;
      ALU_SLL:    res_c = a_i << b_i[SHAMT_W-1:0];
      ALU_SRL:    res_c = a_i >> b_i[SHAMT_W-1:0];
      ALU_SRA:    res_c = XLEN'($signed(a_i) >>> b_i[SHAMT_W-1:0]);
      ALU_SLTS:   res_c = XLEN'($signed(a_i) < $signed(b_i));
      ALU_SLTU:   res_c = XLEN'(a_i < b_i);
      ALU_LTS:    flag_c = $signed(a_i) < $signed(b_i);
      ALU_LTU:    flag_c = a_i < b_i;
      ALU_GES:    flag_c = $signed(a_i) >= $signed(b_i);
      ALU_GEU:    flag_c = a_i >= b_i;
      ALU_EQ:     flag_c = a_i == b_i;
      ALU_NE:     flag_c = a_i != b_i;
      ALU_MUL:    res_c = prod[XLEN-1:0];
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU:  res_c = prod[2*XLEN-1:XLEN];
      // Only the fast-path values matter here; normal divides go to the divider.
      ALU_DIV:    res_c = (b_i == '0) ? '1 : a_i;
      ALU_DIVU:   res_c = '1;
      ALU_REM:    res_c = (b_i == '0) ? a_i : '0;
      ALU_REMU:   res_c = a_i;
      default:    res_c = '0;
    endcase
  end

  div_iter_riscv #(.XLEN(XLEN)) u_div (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (div_start),
    .kill_i     (kill_i && (state_q == ST_DIV)),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quo_o      (div_quo),
    .rem_o      (div_rem)
  );

  assign q_fix = q_neg_q ? -div_quo : div_quo;
  assign r_fix = r_neg_q ? -div_rem : div_rem;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      result_q  <= '0;
      flag_q    <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      rem_sel_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (div_start) begin
            state_q   <= ST_DIV;
            q_neg_q   <= a_neg ^ b_neg;
            r_neg_q   <= a_neg;
            rem_sel_q <= rem_op;
          end else if (accept) begin
            result_q <= res_c;
            flag_q   <= flag_c;
            valid_q  <= 1'b1;
          end
        end
        ST_DIV: begin
          if (kill_i) begin
            state_q <= ST_IDLE;
          end else if (div_done) begin
            // Result lands with the DONE state so valid_o is high exactly while in DONE.
            state_q  <= ST_DONE;
            result_q <= rem_sel_q ? r_fix : q_fix;
            flag_q   <= 1'b0;
            valid_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign flag_o   = flag_q;

endmodule

// File: tb/tb_alu_seq_riscv.sv
// Self-checking bench for alu_seq_riscv: directed scenarios plus random ops
// compared against an arithmetic reference model.
module tb_alu_seq_riscv;
  import alu_opcodes_pkg::*;

  localparam int XLEN = 32;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            valid_i = 1'b0;
  logic            kill_i = 1'b0;
  logic [4:0]      alu_op_i = '0;
  logic [XLEN-1:0] a_i = '0;
  logic [XLEN-1:0] b_i = '0;
  logic            ready_o, valid_o, flag_o;
  logic [XLEN-1:0] result_o;

  int n_tests = 0;
  int n_fail  = 0;

  alu_seq_riscv #(.XLEN(XLEN)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .kill_i   (kill_i),
    .alu_op_i (alu_op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .valid_o  (valid_o),
    .result_o (result_o),
    .flag_o   (flag_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference: {flag, result} from the ISA definitions using 64-bit integers.
  function automatic logic [32:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic [31:0] r;
    logic f;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    r = '0;
    f = 1'b0;
    case (op)
      ALU_ADD:    r = 32'(ua + ub);
      ALU_SUB:    r = 32'(ua - ub);
      ALU_XOR:    r = a ^ b;
      ALU_OR:     r = a | b;
      ALU_AND:    r = a & b;
      ALU_SLL:    r = 32'(ua * (64'd1 << b[4:0]));
      ALU_SRL:    r = 32'(ua / (64'd1 << b[4:0]));
      ALU_SRA:    r = 32'(sa >>> b[4:0]);
      ALU_SLTS:   r = (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU:   r = (ua < ub) ? 32'd1 : 32'd0;
      ALU_LTS:    f = sa < sb;
      ALU_LTU:    f = ua < ub;
      ALU_GES:    f = sa >= sb;
      ALU_GEU:    f = ua >= ub;
      ALU_EQ:     f = ua == ub;
      ALU_NE:     f = ua != ub;
      ALU_MUL:    begin p = ua * ub; r = 32'(p); end
      ALU_MULH:   begin p = sa * sb; r = 32'(p >> 32); end
      ALU_MULHSU: begin p = sa * ub; r = 32'(p >> 32); end
      ALU_MULHU:  begin p = ua * ub; r = 32'(p >> 32); end
      ALU_DIV:    r = (b == 0) ? 32'hFFFF_FFFF : (sa == -64'sd2147483648 && sb == -1) ? a : 32'(sa / sb);
      ALU_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      ALU_REM:    r = (b == 0) ? a : (sa == -64'sd2147483648 && sb == -1) ? 32'd0 : 32'(sa % sb);
      ALU_REMU:   r = (b == 0) ? a : 32'(ua % ub);
      default:    begin r = '0; f = 1'b0; end
    endcase
    return {f, r};
  endfunction

  function automatic int model_latency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!(op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU})) return 1;
    if (b == 0) return 1;
    if ((op == ALU_DIV || op == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  // Issue one op, wait for valid_o (bounded), check latency, stall and results.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] exp;
    int lat, n, rdy_hi;
    exp = model(op, a, b);
    lat = model_latency(op, a, b);
    check({tag, "/ready_before"}, 64'(ready_o), 64'd1);
    valid_i = 1'b1; alu_op_i = op; a_i = a; b_i = b;
    tick();
    valid_i = 1'b0;
    n = 1;
    rdy_hi = 0;
    while (!valid_o && n < 60) begin
      if (ready_o) rdy_hi++;
      tick();
      n++;
    end
    check({tag, "/latency"}, 64'(n), 64'(lat));
    check({tag, "/result"}, 64'(result_o), 64'(exp[31:0]));
    check({tag, "/flag"}, 64'(flag_o), 64'(exp[32]));
    if (lat > 1) begin
      check({tag, "/ready_stall"}, 64'(rdy_hi + int'(ready_o)), 64'd0);
    end
    tick();
    check({tag, "/valid_pulse"}, 64'(valid_o), 64'd0);
    check({tag, "/ready_after"}, 64'(ready_o), 64'd1);
  endtask

  task automatic abort_div(input string tag, input logic use_rst);
    int seen;
    logic [31:0] prev;
    prev = result_o;
    valid_i = 1'b1; alu_op_i = ALU_DIVU; a_i = 32'd1000; b_i = 32'd3;
    tick();
    valid_i = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    if (use_rst) rst_i = 1'b1; else kill_i = 1'b1;
    tick();
    rst_i = 1'b0; kill_i = 1'b0;
    check({tag, "/ready"}, 64'(ready_o), 64'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid_o) seen++;
      tick();
    end
    check({tag, "/no_valid"}, 64'(seen), 64'd0);
    check({tag, "/result_hold"}, 64'(result_o), use_rst ? 64'd0 : 64'(prev));
    check({tag, "/flag"}, 64'(flag_o), 64'd0);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    tick();
    tick();
    check("reset/ready", 64'(ready_o), 64'd1);
    check("reset/valid", 64'(valid_o), 64'd0);
    check("reset/result", 64'(result_o), 64'd0);
    check("reset/flag", 64'(flag_o), 64'd0);
    rst_i = 1'b0;
    tick();
    check("idle/valid", 64'(valid_o), 64'd0);

    // Back-to-back ADD then SUB: one result per cycle, ready stays high.
    valid_i = 1'b1; alu_op_i = ALU_ADD; a_i = 32'd5; b_i = 32'd7;
    tick();
    check("b2b/add_valid", 64'(valid_o), 64'd1);
    check("b2b/add_result", 64'(result_o), 64'h0000_000C);
    check("b2b/ready1", 64'(ready_o), 64'd1);
    alu_op_i = ALU_SUB; a_i = 32'd3; b_i = 32'd5;
    tick();
    valid_i = 1'b0;
    check("b2b/sub_valid", 64'(valid_o), 64'd1);
    check("b2b/sub_result", 64'(result_o), 64'hFFFF_FFFE);
    check("b2b/ready2", 64'(ready_o), 64'd1);
    tick();
    check("b2b/idle", 64'(valid_o), 64'd0);

    run_op("div_neg7_2", ALU_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op("rem_neg7_2", ALU_REM, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_by0", ALU_DIVU, 32'd100, 32'd0);
    run_op("remu_by0", ALU_REMU, 32'd100, 32'd0);
    run_op("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mulh", ALU_MULH, 32'h8000_0000, 32'h8000_0000);
    run_op("mulhu", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhsu", ALU_MULHSU, 32'hFFFF_FFFF, 32'd2);
    run_op("mul", ALU_MUL, 32'h0001_0000, 32'h0001_0000);
    run_op("eq", ALU_EQ, 32'd3, 32'd3);
    run_op("lts", ALU_LTS, 32'hFFFF_FFFF, 32'd1);
    run_op("ltu", ALU_LTU, 32'hFFFF_FFFF, 32'd1);
    run_op("sra", ALU_SRA, 32'h8000_0000, 32'h0000_0021);
    run_op("unknown", 5'd29, 32'd9, 32'd4);
    run_op("seed", ALU_ADD, 32'd5, 32'd7);

    abort_div("kill_div", 1'b0);
    abort_div("rst_div", 1'b1);

    // kill_i together with valid_i in IDLE discards the op.
    valid_i = 1'b1; kill_i = 1'b1; alu_op_i = ALU_ADD; a_i = 32'd1; b_i = 32'd1;
    tick();
    valid_i = 1'b0; kill_i = 1'b0;
    check("kill_idle/valid", 64'(valid_o), 64'd0);
    check("kill_idle/result", 64'(result_o), 64'd0);

    for (int i = 0; i < 300; i++) begin
      logic [4:0] op;
      op = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) op = 5'(ALU_DIV + $urandom_range(0, 3));
      run_op($sformatf("rand%0d_op%0d", i, op), op, pick_val(), pick_val());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
